// File: rtl/pong_pkg.sv
// Shared types and constants for the pong ball controller and its score counters.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } ball_state_e;

  localparam int SCORE_W = 4;
  localparam int STEP_W  = 3;

  localparam logic [SCORE_W-1:0] WIN_SCORE_DEF = 4'd11;
  localparam logic [STEP_W-1:0]  STEP_MAX      = 3'd4;

  function automatic logic [STEP_W-1:0] step_bump(input logic [STEP_W-1:0] s);
    return (s >= STEP_MAX) ? STEP_MAX : s + 3'd1;
  endfunction

endpackage

// File: rtl/ball_ctrl_score_counter.sv
// Saturating per-player score counter; point_o pulses for one cycle on each accepted increment.
module score_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [SCORE_W-1:0] limit_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               point_o
);

  logic [SCORE_W-1:0] score_q;
  logic               point_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      point_q <= 1'b0;
    end else begin
      point_q <= 1'b0;
      if (clr_i) begin
        score_q <= '0;
      end else if (inc_i && (score_q < limit_i)) begin
        score_q <= score_q + 4'd1;
        point_q <= 1'b1;
      end
    end
  end

  assign score_o = score_q;
  assign point_o = point_q;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball position/direction FSM with scoring; define BALL_SPEEDUP_EN to make
// the step grow by one per paddle hit (saturating at 4).
//
//   state  | meaning
//   IDLE   | ball parked at START_X, waiting for serve
//   MOVE   | rally in progress, ball steps on tick
//   SCORED | one-cycle point award, ball re-parked
//   OVER   | a player reached WIN_SCORE, scores frozen
module ball_ctrl
  import pong_pkg::*;
#(
  parameter logic [7:0]         X_MIN     = 8'd8,
  parameter logic [7:0]         X_MAX     = 8'd247,
  parameter logic [7:0]         START_X   = 8'd128,
  parameter logic [SCORE_W-1:0] WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               serve,
  input  logic               hit_l,
  input  logic               hit_r,
  output logic [7:0]         ball_x,
  output logic               dir,
  output logic               active,
  output logic               point_l,
  output logic               point_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  ball_state_e       state_q;
  logic [7:0]        ball_x_q;
  logic              dir_q;
  logic              active_q;
  logic              game_over_q;
  logic [STEP_W-1:0] step;

  logic       moving, at_right, at_left;
  logic       bounce_r, bounce_l, miss_r, miss_l, clr_scores;
  logic [8:0] fwd_sum, back_lim;

  assign moving   = (state_q == ST_MOVE) && tick;
  assign at_right = (ball_x_q >= X_MAX);
  assign at_left  = (ball_x_q <= X_MIN);
  assign bounce_r = moving &&  dir_q && at_right &&  hit_r;
  assign miss_r   = moving &&  dir_q && at_right && !hit_r;
  assign bounce_l = moving && !dir_q && at_left  &&  hit_l;
  assign miss_l   = moving && !dir_q && at_left  && !hit_l;
  assign clr_scores = (state_q == ST_OVER) && serve;

  // 9-bit sums so the clamp compare cannot wrap past the walls
  assign fwd_sum  = {1'b0, ball_x_q} + {6'd0, step};
  assign back_lim = {1'b0, X_MIN} + {6'd0, step};

`ifdef BALL_SPEEDUP_EN
  logic [STEP_W-1:0] step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 3'd1;
    end else if (miss_l || miss_r) begin
      step_q <= 3'd1;
    end else if (bounce_l || bounce_r) begin
      step_q <= step_bump(step_q);
    end
  end

  assign step = step_q;
`else
  assign step = 3'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= START_X;
      dir_q       <= 1'b1;
      active_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ball_x_q <= START_X;
          if (serve) begin
            state_q  <= ST_MOVE;
            active_q <= 1'b1;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            if (dir_q) begin
              if (!at_right) begin
                ball_x_q <= (fwd_sum >= {1'b0, X_MAX}) ? X_MAX : fwd_sum[7:0];
              end else if (hit_r) begin
                dir_q    <= 1'b0;
                ball_x_q <= X_MAX - 8'd1;
              end else begin
                state_q  <= ST_SCORED;
                ball_x_q <= START_X;
                active_q <= 1'b0;
              end
            end else begin
              if (!at_left) begin
                ball_x_q <= ({1'b0, ball_x_q} <= back_lim) ? X_MIN : ball_x_q - {5'd0, step};
              end else if (hit_l) begin
                dir_q    <= 1'b1;
                ball_x_q <= X_MIN + 8'd1;
              end else begin
                state_q  <= ST_SCORED;
                ball_x_q <= START_X;
                active_q <= 1'b0;
              end
            end
          end
        end
        ST_SCORED: begin
          // counters were bumped on entry, so these are the new scores
          if ((score_l == WIN_SCORE) || (score_r == WIN_SCORE)) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OVER: begin
          ball_x_q <= START_X;
          if (serve) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          ball_x_q <= START_X;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  score_counter u_score_l (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_scores),
    .inc_i   (miss_r),
    .limit_i (WIN_SCORE),
    .score_o (score_l),
    .point_o (point_l)
  );

  score_counter u_score_r (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_scores),
    .inc_i   (miss_l),
    .limit_i (WIN_SCORE),
    .score_o (score_r),
    .point_o (point_r)
  );

  assign ball_x    = ball_x_q;
  assign dir       = dir_q;
  assign active    = active_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve, movement, bounces, scoring, game over and reset.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, serve, hit_l, hit_r;
  logic [7:0] ball_x;
  logic       dir, active, point_l, point_r, game_over;
  logic [3:0] score_l, score_r;

  int n_cmp = 0;
  int n_err = 0;

  ball_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .serve     (serve),
    .hit_l     (hit_l),
    .hit_r     (hit_r),
    .ball_x    (ball_x),
    .dir       (dir),
    .active    (active),
    .point_l   (point_l),
    .point_r   (point_r),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input logic [7:0] tgt, input logic d, input string tag);
    for (int i = 0; i < 600; i++) begin
      if (ball_x == tgt && dir == d) break;
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
    chk(tag, {ball_x, 7'd0, dir}, {tgt, 7'd0, d});
  endtask

  initial begin
    logic got;
    rst = 1'b1; tick = 1'b0; serve = 1'b0; hit_l = 1'b0; hit_r = 1'b0;
    repeat (2) cyc();
    chk("rst_ball_x", ball_x, 128);
    chk("rst_dir", dir, 1);
    chk("rst_active", active, 0);
    chk("rst_scores", {score_l, score_r}, 0);
    chk("rst_points", {point_l, point_r}, 0);
    chk("rst_game_over", game_over, 0);
    rst = 1'b0;
    cyc();

    // serve with tick in the same cycle: tick must not move the ball yet
    serve = 1'b1; tick = 1'b1;
    cyc();
    serve = 1'b0; tick = 1'b0;
    chk("serve_active", active, 1);
    chk("serve_ball_x", ball_x, 128);
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    chk("move5_ball_x", ball_x, 133);
    chk("move5_dir", dir, 1);
    chk("move5_active", active, 1);

    hit_r = 1'b1;
    cyc();
    hit_r = 1'b0;
    chk("no_tick_hold", ball_x, 133);
    serve = 1'b1;
    cyc();
    serve = 1'b0;
    chk("serve_in_move_x", ball_x, 133);
    chk("serve_in_move_act", active, 1);

    tick_until(8'd247, 1'b1, "reach_right");
    cyc();
    chk("edge_no_tick", ball_x, 247);
    hit_r = 1'b1; tick = 1'b1;
    cyc();
    hit_r = 1'b0; tick = 1'b0;
    chk("bounce_r_x", ball_x, 246);
    chk("bounce_r_dir", dir, 0);
    chk("bounce_r_points", {point_l, point_r}, 0);
    chk("bounce_r_active", active, 1);

    tick_until(8'd8, 1'b0, "reach_left");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("miss_l_active", active, 0);
    chk("miss_l_point_r", point_r, 1);
    chk("miss_l_point_l", point_l, 0);
    chk("miss_l_score_r", score_r, 1);
    chk("miss_l_score_l", score_l, 0);
    chk("miss_l_ball_x", ball_x, 128);
    // serve during SCORED must be ignored
    serve = 1'b1;
    cyc();
    serve = 1'b0;
    chk("post_score_point_r", point_r, 0);
    chk("post_score_idle", active, 0);
    chk("post_score_dir", dir, 0);
    chk("post_score_go", game_over, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_hold_x", ball_x, 128);
    chk("idle_hold_act", active, 0);

    // left player takes 11 points: ball always returned on the left, missed on the right
    hit_l = 1'b1; hit_r = 1'b0;
    for (int p = 1; p <= 11; p++) begin
      serve = 1'b1;
      cyc();
      serve = 1'b0;
      got = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if (point_l) begin
          got = 1'b1;
          break;
        end
        cyc();
      end
      tick = 1'b0;
      chk("rally_point_l", got, 1);
      chk("rally_score_l", score_l, p);
      if (p == 11) serve = 1'b1;
      cyc();
      serve = 1'b0;
    end
    hit_l = 1'b0;
    chk("over_flag", game_over, 1);
    chk("over_active", active, 0);
    chk("over_score_l", score_l, 11);
    chk("over_score_r", score_r, 1);
    chk("over_ball_x", ball_x, 128);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("over_frozen_l", score_l, 11);
    chk("over_still", game_over, 1);
    serve = 1'b1;
    cyc();
    serve = 1'b0;
    chk("clear_go", game_over, 0);
    chk("clear_scores", {score_l, score_r}, 0);
    chk("clear_dir", dir, 1);
    chk("clear_idle", active, 0);

    // reset in the middle of a rally
    serve = 1'b1;
    cyc();
    serve = 1'b0;
    tick_until(8'd200, 1'b1, "reach_200");
    chk("mid_active", active, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_x", ball_x, 128);
    chk("async_rst_act", active, 0);
    chk("async_rst_scores", {score_l, score_r}, 0);
    chk("async_rst_dir", dir, 1);
    #3;
    rst = 1'b0;
    cyc();
    chk("after_rst_idle", active, 0);

`ifdef BALL_SPEEDUP_EN
    hit_l = 1'b1; hit_r = 1'b1;
    serve = 1'b1;
    cyc();
    serve = 1'b0;
    tick_until(8'd246, 1'b0, "spd_hit1");
    tick_until(8'd9, 1'b1, "spd_hit2");
    tick_until(8'd246, 1'b0, "spd_hit3");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("spd_step4", ball_x, 242);
    tick_until(8'd245, 1'b1, "spd_reach_245");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("spd_clamp", ball_x, 247);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
